// File: rtl/cmd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cmd_packer
// Description : Producer end of the command FIFO drained by the command
//               sequencer. Accepts one layer descriptor at a time, validates
//               it, and serialises it into three 32-bit FIFO words. Counts the
//               commands written and, once sealed, reports the total on
//               cmd_size and pulses op_en to start execution.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   desc_valid/rdy  descriptor handshake (transfer when both high at an edge)
//   op_type..stride2  descriptor fields
//   seal            pulse: no more descriptors will follow
//   fifo_full       command FIFO cannot take a word this cycle
//   wr_en, din      FIFO write strobe and data
//   cmd_size        number of complete commands written
//   op_en           one-cycle start pulse to the sequencer
//   err             sticky error (bad descriptor or seal with no commands)
//   busy            a descriptor is being serialised
// ============================================================================
module cmd_packer #(
  parameter int MAX_CMDS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [2:0]  op_type,
  input  logic [3:0]  stride,
  input  logic [7:0]  kernel,
  input  logic [7:0]  i_side,
  input  logic [7:0]  o_side,
  input  logic [15:0] i_channel,
  input  logic [15:0] o_channel,
  input  logic [7:0]  kernel_size,
  input  logic [15:0] stride2,
  input  logic        seal,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [31:0] din,
  output logic [6:0]  cmd_size,
  output logic        op_en,
  output logic        err,
  output logic        busy
);

  localparam logic [6:0] c_MAX_CMDS = 7'(MAX_CMDS);

  localparam logic [2:0] c_OP_CONV = 3'b001;
  localparam logic [2:0] c_OP_MAXP = 3'b100;
  localparam logic [2:0] c_OP_AVGP = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_W1    = 3'd2,
    S_W2    = 3'd3,
    S_START = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched descriptor fields
  logic [2:0]  r_op_type;
  logic [3:0]  r_stride;
  logic [7:0]  r_kernel;
  logic [7:0]  r_i_side;
  logic [7:0]  r_o_side;
  logic [15:0] r_i_channel;
  logic [15:0] r_o_channel;
  logic [7:0]  r_kernel_size;
  logic [15:0] r_stride2;

  logic [6:0]  r_cmd_size;
  logic        r_err;
  logic        r_seal_pend;

  logic        w_in_w;
  logic        w_accept;
  logic        w_desc_ok;
  logic        w_seal_go;
  logic [11:0] w_prod;

  // --------------------------------------------------------------------------
  // Descriptor validation (purely on the live input fields)
  // --------------------------------------------------------------------------
  // kernel*stride is at most 255*15 = 3825, so 12 bits hold it exactly.
  assign w_prod = 12'(kernel) * 12'(stride);

  assign w_desc_ok = ((op_type == c_OP_CONV) || (op_type == c_OP_MAXP) ||
                      (op_type == c_OP_AVGP))              &&
                     (stride != 4'd0) && (kernel != 8'd0)  &&
                     (i_side != 8'd0)                      &&
                     ({4'd0, stride} <= kernel)            &&
                     (stride2 == {4'd0, w_prod});

  // --------------------------------------------------------------------------
  // Handshake / control decode
  // --------------------------------------------------------------------------
  assign w_in_w = (r_state == S_W0) || (r_state == S_W1) || (r_state == S_W2);

  // A pending seal blocks new descriptors so it is served before anything
  // else on the return to IDLE; this keeps desc_ready an honest promise.
  assign desc_ready = (r_state == S_IDLE) && (r_cmd_size < c_MAX_CMDS) &&
                      !r_seal_pend;
  assign w_accept   = desc_valid && desc_ready;

  // A seal is acted on in IDLE only when no descriptor is taken that cycle;
  // a simultaneous descriptor wins and the seal is parked in r_seal_pend.
  assign w_seal_go  = (r_state == S_IDLE) && !w_accept && (seal || r_seal_pend);

  assign wr_en = w_in_w && !fifo_full;
  assign busy  = w_in_w;
  assign op_en = (r_state == S_START);

  assign cmd_size = r_cmd_size;
  assign err      = r_err;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_desc_ok) begin
          w_next = S_W0;
        end else if (w_seal_go && (r_cmd_size != 7'd0)) begin
          w_next = S_START;
        end
      end
      S_W0:    if (wr_en) w_next = S_W1;
      S_W1:    if (wr_en) w_next = S_W2;
      S_W2:    if (wr_en) w_next = S_IDLE;
      S_START: w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write data mux: driven from latched fields, so it holds through stalls
  // --------------------------------------------------------------------------
  always_comb begin
    din = 32'd0;
    case (r_state)
      S_W0:    din = {r_o_side, r_i_side, r_kernel, r_stride, 1'b0, r_op_type};
      S_W1:    din = {r_o_channel, r_i_channel};
      S_W2:    din = {r_stride2, r_kernel_size, 8'd0};
      default: din = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op_type     <= 3'd0;
      r_stride      <= 4'd0;
      r_kernel      <= 8'd0;
      r_i_side      <= 8'd0;
      r_o_side      <= 8'd0;
      r_i_channel   <= 16'd0;
      r_o_channel   <= 16'd0;
      r_kernel_size <= 8'd0;
      r_stride2     <= 16'd0;
      r_cmd_size    <= 7'd0;
      r_err         <= 1'b0;
      r_seal_pend   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_op_type     <= op_type;
        r_stride      <= stride;
        r_kernel      <= kernel;
        r_i_side      <= i_side;
        r_o_side      <= o_side;
        r_i_channel   <= i_channel;
        r_o_channel   <= o_channel;
        r_kernel_size <= kernel_size;
        r_stride2     <= stride2;
      end

      // Sticky: a dropped descriptor, or a seal with nothing to run.
      if ((w_accept && !w_desc_ok) ||
          (w_seal_go && (r_cmd_size == 7'd0))) begin
        r_err <= 1'b1;
      end

      if ((w_in_w && seal) || (w_accept && seal)) begin
        r_seal_pend <= 1'b1;
      end else if (w_seal_go) begin
        r_seal_pend <= 1'b0;
      end

      // A command counts only once its last word has gone into the FIFO.
      if ((r_state == S_W2) && wr_en) begin
        r_cmd_size <= r_cmd_size + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cmd_packer
// Description : Self-checking bench for cmd_packer. A queue-based reference
//               model predicts every output each cycle; directed scenarios add
//               literal expectations, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_packer;

  localparam int c_MAXC = 3;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] ich;
    logic [15:0] och;
    logic [7:0]  ksize;
    logic [15:0] stride2;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [2:0]  op_type = '0;
  logic [3:0]  stride = '0;
  logic [7:0]  kernel = '0;
  logic [7:0]  i_side = '0;
  logic [7:0]  o_side = '0;
  logic [15:0] i_channel = '0;
  logic [15:0] o_channel = '0;
  logic [7:0]  kernel_size = '0;
  logic [15:0] stride2 = '0;
  logic        seal = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [31:0] din;
  logic [6:0]  cmd_size;
  logic        op_en;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  cmd_packer #(.MAX_CMDS(c_MAXC)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .op_type(op_type), .stride(stride), .kernel(kernel),
    .i_side(i_side), .o_side(o_side),
    .i_channel(i_channel), .o_channel(o_channel),
    .kernel_size(kernel_size), .stride2(stride2),
    .seal(seal), .fifo_full(fifo_full),
    .wr_en(wr_en), .din(din), .cmd_size(cmd_size),
    .op_en(op_en), .err(err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: pending FIFO words plus a few flags
  // --------------------------------------------------------------------------
  logic [31:0] q_words[$];
  int          m_cnt   = 0;
  bit          m_err   = 0;
  bit          m_pend  = 0;
  bit          m_start = 0;
  bit          m_done  = 0;
  bit          m_valid = 0;

  logic [31:0] wr_log[$];
  int          op_cnt = 0;

  function automatic bit desc_is_valid(desc_t d);
    return ((d.op == 3'd1) || (d.op == 3'd4) || (d.op == 3'd5)) &&
           (d.stride != 0) && (d.kernel != 0) && (d.i_side != 0) &&
           (int'(d.stride) <= int'(d.kernel)) &&
           (int'(d.stride2) == int'(d.kernel) * int'(d.stride));
  endfunction

  function automatic logic [31:0] word_of(desc_t d, int k);
    if (k == 0) return {d.o_side, d.i_side, d.kernel, d.stride, 1'b0, d.op};
    if (k == 1) return {d.och, d.ich};
    return {d.stride2, d.ksize, 8'd0};
  endfunction

  function automatic bit exp_busy();
    return q_words.size() > 0;
  endfunction

  function automatic bit exp_ready();
    return !exp_busy() && !m_start && !m_done && !m_pend && (m_cnt < c_MAXC);
  endfunction

  function automatic desc_t cur_desc();
    desc_t d;
    d.op = op_type; d.stride = stride; d.kernel = kernel;
    d.i_side = i_side; d.o_side = o_side; d.ich = i_channel;
    d.och = o_channel; d.ksize = kernel_size; d.stride2 = stride2;
    return d;
  endfunction

  task automatic model_step();
    bit rdy;
    desc_t d;
    if (rst) begin
      q_words.delete();
      m_cnt = 0; m_err = 0; m_pend = 0; m_start = 0; m_done = 0;
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    rdy = exp_ready();
    d   = cur_desc();
    if (exp_busy()) begin
      if (!fifo_full) begin
        void'(q_words.pop_front());
        if (q_words.size() == 0) m_cnt++;
      end
      if (seal) m_pend = 1;
    end else if (m_start) begin
      m_start = 0;
      m_done  = 1;
    end else if (m_done) begin
      m_done = 1;
    end else if (rdy && desc_valid) begin
      if (desc_is_valid(d)) begin
        for (int k = 0; k < 3; k++) q_words.push_back(word_of(d, k));
      end else begin
        m_err = 1;
      end
      if (seal) m_pend = 1;
    end else if (seal || m_pend) begin
      m_pend = 0;
      if (m_cnt == 0) m_err = 1;
      else m_start = 1;
    end
  endtask

  // Single compare process: outputs are checked mid-cycle, then the model
  // advances using the inputs that the coming edge will sample.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("desc_ready", 32'(desc_ready), 32'(exp_ready()));
      chk("wr_en",      32'(wr_en),      32'(exp_busy() && !fifo_full));
      chk("din",        din,             exp_busy() ? q_words[0] : 32'd0);
      chk("busy",       32'(busy),       32'(exp_busy()));
      chk("op_en",      32'(op_en),      32'(m_start));
      chk("cmd_size",   32'(cmd_size),   32'(m_cnt));
      chk("err",        32'(err),        32'(m_err));
    end
    if (wr_en === 1'b1) wr_log.push_back(din);
    if (op_en === 1'b1) op_cnt++;
    model_step();
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1ns after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input desc_t d);
    op_type = d.op; stride = d.stride; kernel = d.kernel;
    i_side = d.i_side; o_side = d.o_side; i_channel = d.ich;
    o_channel = d.och; kernel_size = d.ksize; stride2 = d.stride2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_log.delete();
    op_cnt = 0;
  endtask

  task automatic send(input desc_t d, input int maxw, output bit acc);
    bit r;
    apply(d);
    desc_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk);
      r = desc_ready;
      tick();
      if (r) begin
        acc = 1;
        break;
      end
    end
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        tick();
        return;
      end
      tick();
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_seal();
    seal = 1'b1;
    tick();
    seal = 1'b0;
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    int    smax;
    case ($urandom_range(0, 2))
      0:       d.op = 3'b001;
      1:       d.op = 3'b100;
      default: d.op = 3'b101;
    endcase
    d.kernel  = 8'($urandom_range(1, 255));
    smax      = (int'(d.kernel) < 15) ? int'(d.kernel) : 15;
    d.stride  = 4'($urandom_range(1, smax));
    d.i_side  = 8'($urandom_range(1, 255));
    d.o_side  = 8'($urandom);
    d.ich     = 16'($urandom);
    d.och     = 16'($urandom);
    d.ksize   = 8'($urandom);
    d.stride2 = 16'(int'(d.kernel) * int'(d.stride));
    case ($urandom_range(0, 11))
      0: d.op      = 3'($urandom_range(0, 7));
      1: d.stride  = 4'd0;
      2: d.kernel  = 8'($urandom_range(0, 3));
      3: d.i_side  = 8'd0;
      4: d.stride2 = d.stride2 ^ 16'($urandom_range(1, 65535));
      5: d.stride  = 4'($urandom);
      default: ;
    endcase
    return d;
  endfunction

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    desc_t conv, d;
    bit    acc;

    conv.op = 3'b001; conv.stride = 4'd1; conv.kernel = 8'd3;
    conv.i_side = 8'd227; conv.o_side = 8'd225; conv.ich = 16'd3;
    conv.och = 16'd64; conv.ksize = 8'd9; conv.stride2 = 16'd3;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_desc_ready", 32'(desc_ready), 32'd1);
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_din",        din,             32'd0);
    chk("rst_cmd_size",   32'(cmd_size),   32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    tick();

    // Single conv descriptor then seal
    wr_log.delete();
    send(conv, 10, acc);
    chk("t1_accept", 32'(acc), 32'd1);
    wait_idle();
    chk("t1_nwords", 32'(wr_log.size()), 32'd3);
    chk("t1_w0", wr_log[0], 32'hE1E30311);
    chk("t1_w1", wr_log[1], 32'h00400003);
    chk("t1_w2", wr_log[2], 32'h00030900);
    op_cnt = 0;
    pulse_seal();
    repeat (3) tick();
    chk("t1_cmd_size", 32'(cmd_size), 32'd1);
    chk("t1_op_en_cnt", 32'(op_cnt), 32'd1);
    chk("t1_done_ready", 32'(desc_ready), 32'd0);

    // FIFO stall during W1
    do_reset();
    send(conv, 10, acc);
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_wr_en", 32'(wr_en), 32'd0);
      chk("t2_stall_din",   din,        32'h00400003);
      tick();
    end
    fifo_full = 1'b0;
    wait_idle();
    chk("t2_nwords", 32'(wr_log.size()), 32'd3);
    chk("t2_w1",     wr_log[1],          32'h00400003);

    // Invalid descriptors dropped, then a valid one
    do_reset();
    d = conv; d.op = 3'b010;
    send(d, 10, acc);
    repeat (4) tick();
    chk("t3_bad_op_writes", 32'(wr_log.size()), 32'd0);
    chk("t3_bad_op_err",    32'(err),           32'd1);
    d = conv; d.kernel = 8'd3; d.stride = 4'd2; d.stride2 = 16'd5;
    send(d, 10, acc);
    repeat (4) tick();
    chk("t3_bad_s2_writes", 32'(wr_log.size()), 32'd0);
    chk("t3_bad_cmd_size",  32'(cmd_size),      32'd0);
    send(conv, 10, acc);
    wait_idle();
    chk("t3_good_writes",   32'(wr_log.size()), 32'd3);
    chk("t3_good_cmd_size", 32'(cmd_size),      32'd1);

    // Seal during W1 of the second descriptor
    do_reset();
    send(conv, 10, acc);
    wait_idle();
    op_cnt = 0;
    d = conv; d.o_side = 8'd17;
    send(d, 10, acc);
    tick();
    pulse_seal();
    wait_idle();
    repeat (3) tick();
    chk("t4_cmd_size",   32'(cmd_size), 32'd2);
    chk("t4_op_en_cnt",  32'(op_cnt),   32'd1);
    chk("t4_nwords",     32'(wr_log.size()), 32'd6);

    // Command cap, then seal with nothing queued
    do_reset();
    for (int i = 0; i < c_MAXC; i++) begin
      d = conv; d.ich = 16'(i);
      send(d, 20, acc);
      chk("t5_accept", 32'(acc), 32'd1);
    end
    send(conv, 12, acc);
    chk("t5_over_cap_accept", 32'(acc), 32'd0);
    @(negedge clk);
    chk("t5_cap_ready", 32'(desc_ready), 32'd0);
    tick();
    pulse_seal();
    repeat (3) tick();
    chk("t5_cap_op_en_cnt", 32'(op_cnt),   32'd1);
    chk("t5_cap_cmd_size",  32'(cmd_size), 32'(c_MAXC));
    do_reset();
    pulse_seal();
    repeat (3) tick();
    chk("t5_empty_err",      32'(err),    32'd1);
    chk("t5_empty_op_en",    32'(op_cnt), 32'd0);

    // Reset during W2
    do_reset();
    d = conv; d.op = 3'b111;
    send(d, 10, acc);
    send(conv, 10, acc);
    tick();
    tick();
    @(negedge clk);
    chk("t6_in_w2_din", din, 32'h00030900);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_wr_en",      32'(wr_en),      32'd0);
    chk("t6_cmd_size",   32'(cmd_size),   32'd0);
    chk("t6_err",        32'(err),        32'd0);
    chk("t6_desc_ready", 32'(desc_ready), 32'd1);
    tick();

    // Randomized phase, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      apply(rand_desc());
      desc_valid = ($urandom_range(0, 1) == 1);
      seal       = ($urandom_range(0, 39) == 0);
      fifo_full  = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 79) == 0);
      tick();
    end
    desc_valid = 1'b0; seal = 1'b0; fifo_full = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
